// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared types, constants and the segment decoder for the 7-segment scan
// driver and its binary-to-BCD conversion engine.
//   bcd_digit_t  : one packed BCD digit
//   cvt_state_t  : conversion FSM states
//   SEG_LUT      : active-low {g,f,e,d,c,b,a} patterns for digits 0-9
//   seg_decode() : digit -> segment pattern, dash for non-decimal codes
// -----------------------------------------------------------------------------
package seg7_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } cvt_state_t;

  localparam int unsigned BIN_W      = 10;
  localparam int unsigned BCD_W      = 16;
  localparam int unsigned SHIFT_LAST = 9;  // shift cycles are numbered 0..9

  localparam logic [6:0] SEG_LUT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Codes above 9 cannot come out of the converter; show a dash if one does.
  function automatic logic [6:0] seg_decode(input bcd_digit_t d);
    logic [6:0] seg;
    if (d > 4'd9) begin
      seg = SEG_DASH;
    end else begin
      seg = SEG_LUT[d];
    end
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_if
// Load/status and display-pin bundle of the 7-segment scan driver.
//   value[9:0]   : binary value to show        (master -> slave)
//   load         : 1-cycle capture strobe      (master -> slave)
//   busy         : conversion in progress      (slave -> master)
//   bcd_ready    : new digits committed pulse  (slave -> master)
//   led_out[6:0] : active-low segments {g..a}  (slave -> master)
//   anode[3:0]   : active-low one-hot anodes   (slave -> master)
// -----------------------------------------------------------------------------
interface seg7_scan_driver_if;

  logic [9:0] value;
  logic       load;
  logic       busy;
  logic       bcd_ready;
  logic [6:0] led_out;
  logic [3:0] anode;

  modport master (
    output value, load,
    input  busy, bcd_ready, led_out, anode
  );

  modport slave (
    input  value, load,
    output busy, bcd_ready, led_out, anode
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter: 10-bit binary to four BCD digits.
// One shift per cycle, 10 shift cycles, then a single COMMIT cycle.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : capture bin and begin (accepted only in IDLE)
//   bin[9:0]   : binary input, sampled only on an accepted start
//   busy       : high from the cycle after start through COMMIT
//   done       : high during the COMMIT cycle; bcd is final then
//   bcd[15:0]  : BCD working/result register, digit 0 in [3:0]
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  cvt_state_t       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [BIN_W-1:0] sr_q, sr_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [BCD_W-1:0] bcd_adj;

  // Add 3 to every nibble that is 5 or more so the following shift carries correctly.
  function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
      end else begin
        r[i*4 +: 4] = b[i*4 +: 4];
      end
    end
    return r;
  endfunction

  // Next-state, datapath and status computation for the conversion FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    bcd_d   = bcd_q;
    bcd_adj = add3_all(bcd_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = bin;
          bcd_d   = '0;
          cnt_d   = 4'd0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // Max input is 1023, so the adjusted MSB is always 0 and drops off.
        bcd_d = (bcd_adj << 1) | {{(BCD_W-1){1'b0}}, sr_q[BIN_W-1]};
        sr_d  = sr_q << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(SHIFT_LAST)) begin
          state_d = COMMIT;
        end else begin
          state_d = SHIFT;
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status is registered from the next state so it lines up with state_q.
    busy_d = (state_d != IDLE);
    done_d = (state_d == COMMIT);
  end

  // State, datapath and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sr_q    <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Display back-end: converts a 10-bit value to BCD and time-multiplexes the
// digits onto a 4-digit common-anode 7-segment display.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : seg7_scan_driver_if.slave (value/load in; busy, bcd_ready,
//                led_out, anode out)
// Parameters:
//   REFRESH_DIV : clocks each digit stays lit (>= 2)
//   BLANK_LEAD  : 1 blanks leading zero digits (digit 0 is always shown)
// -----------------------------------------------------------------------------
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100_000,
  parameter bit          BLANK_LEAD  = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_driver_if.slave  bus
);

  localparam int unsigned         CNT_W   = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic             cvt_busy;
  logic             cvt_done;
  logic [BCD_W-1:0] cvt_bcd;

  logic [CNT_W-1:0] refresh_q, refresh_d;
  logic [1:0]       scan_q, scan_d;
  logic [BCD_W-1:0] digits_q, digits_d;
  logic [6:0]       led_q, led_d;
  logic [3:0]       anode_q, anode_d;
  bcd_digit_t       cur_digit;
  logic             blank;

  bin2bcd_seq u_cvt (
    .clk   (clk),
    .rst_n (rst_n),
    .start (bus.load),
    .bin   (bus.value),
    .busy  (cvt_busy),
    .done  (cvt_done),
    .bcd   (cvt_bcd)
  );

  // Refresh counter, scan index, digit commit and next output pattern.
  always_comb begin
    if (refresh_q == CNT_MAX) begin
      refresh_d = '0;
      scan_d    = scan_q + 2'd1;
    end else begin
      refresh_d = refresh_q + CNT_W'(1);
      scan_d    = scan_q;
    end

    // All four digits are swapped together so a scan never mixes old and new.
    if (cvt_done) begin
      digits_d = cvt_bcd;
    end else begin
      digits_d = digits_q;
    end

    // A digit is a leading zero when it and every digit above it are zero.
    case (scan_q)
      2'd0: begin
        cur_digit = digits_q[3:0];
        blank     = 1'b0;
      end
      2'd1: begin
        cur_digit = digits_q[7:4];
        blank     = (digits_q[15:4] == 12'd0);
      end
      2'd2: begin
        cur_digit = digits_q[11:8];
        blank     = (digits_q[15:8] == 8'd0);
      end
      2'd3: begin
        cur_digit = digits_q[15:12];
        blank     = (digits_q[15:12] == 4'd0);
      end
      default: begin
        cur_digit = 4'd0;
        blank     = 1'b0;
      end
    endcase

    if (BLANK_LEAD && blank) begin
      led_d = SEG_BLANK;
    end else begin
      led_d = seg_decode(cur_digit);
    end
    anode_d = ~(4'b0001 << scan_q);
  end

  // Scan state, committed digits and registered display pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refresh_q <= '0;
      scan_q    <= 2'd0;
      digits_q  <= '0;
      led_q     <= SEG_BLANK;
      anode_q   <= 4'hF;
    end else begin
      refresh_q <= refresh_d;
      scan_q    <= scan_d;
      digits_q  <= digits_d;
      led_q     <= led_d;
      anode_q   <= anode_d;
    end
  end

  assign bus.busy      = cvt_busy;
  assign bus.bcd_ready = cvt_done;
  assign bus.led_out   = led_q;
  assign bus.anode     = anode_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Directed bench for seg7_scan_driver with REFRESH_DIV=4. Two instances share
// the stimulus: one with leading-zero blanking, one without.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] value_s = 10'd0;
  logic       load_s = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  seg7_scan_driver_if if_bl ();
  seg7_scan_driver_if if_nb ();

  assign if_bl.value = value_s;
  assign if_bl.load  = load_s;
  assign if_nb.value = value_s;
  assign if_nb.load  = load_s;

  seg7_scan_driver #(.REFRESH_DIV(4), .BLANK_LEAD(1'b1)) u_dut_bl (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_bl)
  );

  seg7_scan_driver #(.REFRESH_DIV(4), .BLANK_LEAD(1'b0)) u_dut_nb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_nb)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]      value;
    logic [3:0][6:0] exp_bl;  // index = digit position
    logic [3:0][6:0] exp_nb;
  } vec_t;

  vec_t vecs [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Load v, optionally a second load at cycle k2, optionally reset at cycle rst_k.
  task automatic do_load(input logic [9:0] v, input logic [9:0] v2, input int k2,
                         input int rst_k, output int ready_k, output int ready_cnt,
                         output int busy_n);
    ready_k = 0;
    ready_cnt = 0;
    busy_n = 0;
    @(negedge clk);
    value_s = v;
    load_s  = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) begin
        load_s  = 1'b0;
        value_s = 10'd555;
      end
      if (k == k2) begin
        load_s  = 1'b1;
        value_s = v2;
      end
      if (k == k2 + 1) begin
        load_s  = 1'b0;
        value_s = 10'd555;
      end
      if (k == rst_k) rst_n = 1'b0;
      if (k == rst_k + 1) rst_n = 1'b1;
      if (if_bl.busy) busy_n++;
      if (if_bl.bcd_ready) begin
        ready_cnt++;
        if (ready_k == 0) ready_k = k;
      end
    end
  endtask

  // Observe 20 cycles of both displays; check anode order and 4-clock dwell.
  task automatic scan(input string tag, output logic [3:0][6:0] got_bl,
                      output logic [3:0][6:0] got_nb);
    logic [3:0] prev;
    int run;
    bit first_change;
    got_bl = 'x;
    got_nb = 'x;
    prev = if_bl.anode;
    run = 0;
    first_change = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      case (if_bl.anode)
        4'hE: got_bl[0] = if_bl.led_out;
        4'hD: got_bl[1] = if_bl.led_out;
        4'hB: got_bl[2] = if_bl.led_out;
        4'h7: got_bl[3] = if_bl.led_out;
        default: chk({tag, " anode one-hot"}, {28'd0, if_bl.anode}, 32'hE);
      endcase
      case (if_nb.anode)
        4'hE: got_nb[0] = if_nb.led_out;
        4'hD: got_nb[1] = if_nb.led_out;
        4'hB: got_nb[2] = if_nb.led_out;
        4'h7: got_nb[3] = if_nb.led_out;
        default: chk({tag, " nb anode one-hot"}, {28'd0, if_nb.anode}, 32'hE);
      endcase
      run++;
      if (if_bl.anode != prev) begin
        chk({tag, " anode order"}, {28'd0, if_bl.anode}, {28'd0, prev[2:0], prev[3]});
        if (!first_change) chk({tag, " dwell"}, run, 32'd4);
        first_change = 1'b0;
        run = 0;
        prev = if_bl.anode;
      end
    end
  endtask

  task automatic chk_digits(input string tag, input logic [3:0][6:0] got_bl,
                            input logic [3:0][6:0] got_nb, input logic [3:0][6:0] exp_bl,
                            input logic [3:0][6:0] exp_nb);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s blank d%0d", tag, d), {25'd0, got_bl[d]}, {25'd0, exp_bl[d]});
      chk($sformatf("%s noblank d%0d", tag, d), {25'd0, got_nb[d]}, {25'd0, exp_nb[d]});
    end
  endtask

  initial begin
    logic [3:0][6:0] got_bl, got_nb;
    int rk, rc, bn;

    vecs[0].value = 10'd937;
    vecs[0].exp_bl = {7'h7F, 7'h10, 7'h30, 7'h78};
    vecs[0].exp_nb = {7'h40, 7'h10, 7'h30, 7'h78};
    vecs[1].value = 10'd1023;
    vecs[1].exp_bl = {7'h79, 7'h40, 7'h24, 7'h30};
    vecs[1].exp_nb = {7'h79, 7'h40, 7'h24, 7'h30};
    vecs[2].value = 10'd5;
    vecs[2].exp_bl = {7'h7F, 7'h7F, 7'h7F, 7'h12};
    vecs[2].exp_nb = {7'h40, 7'h40, 7'h40, 7'h12};

    // Reset held for three edges.
    repeat (3) @(negedge clk);
    chk("reset led_out", {25'd0, if_bl.led_out}, 32'h7F);
    chk("reset anode", {28'd0, if_bl.anode}, 32'hF);
    chk("reset busy", {31'd0, if_bl.busy}, 32'd0);
    chk("reset bcd_ready", {31'd0, if_bl.bcd_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset led_out", {25'd0, if_bl.led_out}, 32'h40);
    chk("post-reset anode", {28'd0, if_bl.anode}, 32'hE);
    scan("reset", got_bl, got_nb);
    chk_digits("reset", got_bl, got_nb, {7'h7F, 7'h7F, 7'h7F, 7'h40},
               {7'h40, 7'h40, 7'h40, 7'h40});

    // Table-driven conversions.
    for (int i = 0; i < 3; i++) begin
      do_load(vecs[i].value, 10'd0, 0, 0, rk, rc, bn);
      chk($sformatf("v%0d busy cycles", vecs[i].value), bn, 32'd11);
      chk($sformatf("v%0d ready cycle", vecs[i].value), rk, 32'd11);
      chk($sformatf("v%0d ready pulses", vecs[i].value), rc, 32'd1);
      scan($sformatf("v%0d", vecs[i].value), got_bl, got_nb);
      chk_digits($sformatf("v%0d", vecs[i].value), got_bl, got_nb,
                 vecs[i].exp_bl, vecs[i].exp_nb);
    end

    // Second load while busy is dropped.
    do_load(10'd200, 10'd77, 3, 0, rk, rc, bn);
    chk("drop ready cycle", rk, 32'd11);
    chk("drop ready pulses", rc, 32'd1);
    scan("v200", got_bl, got_nb);
    chk_digits("v200", got_bl, got_nb, {7'h7F, 7'h24, 7'h40, 7'h40},
               {7'h40, 7'h24, 7'h40, 7'h40});

    // Reset mid-conversion aborts it and clears the display.
    do_load(10'd512, 10'd0, 0, 5, rk, rc, bn);
    chk("abort ready pulses", rc, 32'd0);
    chk("abort busy cycles", bn, 32'd5);
    scan("abort", got_bl, got_nb);
    chk_digits("abort", got_bl, got_nb, {7'h7F, 7'h7F, 7'h7F, 7'h40},
               {7'h40, 7'h40, 7'h40, 7'h40});

    do_load(10'd42, 10'd0, 0, 0, rk, rc, bn);
    chk("v42 ready cycle", rk, 32'd11);
    chk("v42 busy cycles", bn, 32'd11);
    scan("v42", got_bl, got_nb);
    chk_digits("v42", got_bl, got_nb, {7'h7F, 7'h7F, 7'h19, 7'h24},
               {7'h40, 7'h40, 7'h19, 7'h24});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
